dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-side memory responder for the pipelined MIPS core: the slave end of the core's M-stage data port (memwriteM / aluoutM / writedataM → readdataM). It holds a word-addressed data RAM plus a small memory-mapped I/O window: a free-running cycle counter, a GPIO output register and a compare/auto-reload timer with an interrupt flag. It responds with zero wait states, so the core needs no handshake or stall path.

## Interface
- RAM_WORDS, 64: data RAM depth in 32-bit words, power of two.
- MMIO_BASE, 32'hFFFF_FF00: base of the 256-byte MMIO window.
- GPIO_W, 8: width of the GPIO output register.

- clk  in  1  core clock; all state updates on posedge.
- reset_n  in  1  reset, asynchronous and active-low.
- memwriteM  in  1  store strobe from the core's M stage.
- aluoutM  in  32  byte address; bits [1:0] ignored.
- writedataM  in  32  store data.
- readdataM  out  32  load data, combinational from aluoutM.
- gpio_out  out  GPIO_W  GPIO register contents.
- timer_irq  out  1  timer pending flag.

## Operation
- Decode: MMIO when aluoutM[31:8] == MMIO_BASE[31:8]; otherwise RAM.
- RAM index: aluoutM[log2(RAM_WORDS)+1:2]. Higher address bits are ignored, so the array aliases modulo RAM_WORDS.
- RAM is not reset. A never-written word reads X.
- MMIO offsets (aluoutM[7:2]):
  - 0x00 CYCLE, RO: 32-bit counter, +1 every clk, wraps at 0xFFFF_FFFF→0. Writes ignored.
  - 0x04 GPIO, RW: low GPIO_W bits stored. Reads zero-extend.
  - 0x08 TCMP, RW: timer compare value.
  - 0x0C TCTRL:
    - bit0 EN, RW.
    - bit1 AUTO, RW.
    - bit2 PEND: read; write-1-clears.
    - Other bits read 0.
  - 0x10 TCNT, RW: timer count.
  - Other offsets read 0. Writes to them are ignored.
- Timer, evaluated each clk on pre-edge values:
  - If EN and TCNT == TCMP: set PEND. If AUTO, TCNT←0; else EN←0 and TCNT holds.
  - Else if EN: TCNT←TCNT+1 (wraps).
- Collision rules:
  - A CPU write to TCNT or TCTRL.EN/AUTO in the same cycle overrides the timer's own update of that field.
  - A match still sets PEND when the write lands on the match cycle.
  - PEND: a hardware set in the same cycle as a W1C write leaves PEND=1.
- timer_irq = PEND.

## Timing
- Reads: zero latency. readdataM is valid in the same cycle aluoutM is presented and reflects pre-edge state.
- Read and write to the same address in one cycle return the old value. The new value is visible from the next cycle.
- Writes commit on the posedge at the end of the cycle in which memwriteM=1.
- While reset_n=0, all of the following are 0:
  - registers: CYCLE, GPIO, TCMP, TCTRL, TCNT
  - outputs: gpio_out, timer_irq
- readdataM while reset_n=0:
  - 0 for MMIO addresses
  - RAM contents for RAM addresses
- Reset asserted mid-operation clears all MMIO state immediately, without waiting for clk. An in-flight store on that cycle is dropped.
- First CYCLE increment happens on the first posedge after reset_n rises.
- Timer period with AUTO=1: TCMP+1 cycles between PEND sets, measured from TCNT=0.

## Test plan
- RAM write/read, aliasing and read-during-write:
  - Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 → 0xDEADBEEF.
  - Load 0x0000_0110 (aliases at RAM_WORDS=64) → 0xDEADBEEF.
  - Same-cycle store 0x1 and load of 0x10 → load returns old 0xDEADBEEF.
- GPIO and unmapped offsets:
  - Store 0x1234_56A5 to 0xFFFF_FF04 → gpio_out=0xA5 next cycle; load returns 0x0000_00A5.
  - Load 0xFFFF_FF20 → 0.
- CYCLE counter: release reset, then load 0xFFFF_FF00 at the 10th posedge after release → 10. A store of 0 to it is ignored.
- One-shot timer:
  - Setup: TCMP=3, TCNT=0, TCTRL=0x1.
  - Result: PEND/timer_irq rises 4 cycles after EN is set, EN clears, TCNT holds at 3.
  - Store 0x4 to TCTRL → timer_irq=0.
- Auto-reload timer and collision:
  - Setup: TCMP=2, TCTRL=0x3.
  - Result: PEND sets every 3 cycles and TCNT cycles 0,1,2,0.
  - W1C on a set cycle → PEND stays 1.
- Async reset: drop reset_n between clock edges while the timer is running → timer_irq, gpio_out, TCNT and CYCLE read 0 immediately, with no clk edge needed.

Source files
------------

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: the core's M-stage data port.
//   memwriteM  : store strobe (core -> responder)
//   aluoutM    : byte address, bits [1:0] ignored (core -> responder)
//   writedataM : store data (core -> responder)
//   readdataM  : load data, combinational from aluoutM (responder -> core)
// There is no handshake because the responder has zero wait states.
interface dmem_responder_if;
    logic        memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;

    modport master (
        output memwriteM,
        output aluoutM,
        output writedataM,
        input  readdataM
    );

    modport slave (
        input  memwriteM,
        input  aluoutM,
        input  writedataM,
        output readdataM
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data-side memory responder for the pipelined MIPS core.
// It contains a word-addressed data RAM that is not reset and aliases modulo RAM_WORDS.
// It also decodes a 256-byte MMIO window holding these registers:
//   0x00 CYCLE (RO), 0x04 GPIO, 0x08 TCMP, 0x0C TCTRL {PEND(W1C),AUTO,EN}, 0x10 TCNT.
// Ports:
//   clk, reset_n : core clock, asynchronous active-low reset
//   bus          : slave end of the M-stage data port
//   gpio_out     : GPIO register contents
//   timer_irq    : timer pending flag (TCTRL.PEND)
module dmem_responder #(
    parameter int unsigned RAM_WORDS = 64,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00,
    parameter int unsigned GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    dmem_responder_if.slave   bus,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    localparam logic [5:0] OFF_CYCLE = 6'h00;
    localparam logic [5:0] OFF_GPIO  = 6'h01;
    localparam logic [5:0] OFF_TCMP  = 6'h02;
    localparam logic [5:0] OFF_TCTRL = 6'h03;
    localparam logic [5:0] OFF_TCNT  = 6'h04;

    logic [31:0]       mem_q [RAM_WORDS];

    logic [31:0]       cycle_q, cycle_d;
    logic [GPIO_W-1:0] gpio_q,  gpio_d;
    logic [31:0]       tcmp_q,  tcmp_d;
    logic [31:0]       tcnt_q,  tcnt_d;
    logic              en_q,    en_d;
    logic              auto_q,  auto_d;
    logic              pend_q,  pend_d;

    logic              is_mmio;
    logic [5:0]        off;
    logic [AW-1:0]     ram_idx;
    logic              wr_mmio;
    logic              ram_we;
    logic              match;
    logic              unused_addr_lsbs;

    assign is_mmio = (bus.aluoutM[31:8] == MMIO_BASE[31:8]);
    assign off     = bus.aluoutM[7:2];
    assign ram_idx = bus.aluoutM[AW+1:2];
    assign wr_mmio = bus.memwriteM && is_mmio;
    // A store presented while reset is asserted is dropped.
    assign ram_we  = bus.memwriteM && !is_mmio && reset_n;
    assign match   = en_q && (tcnt_q == tcmp_q);
    assign unused_addr_lsbs = ^bus.aluoutM[1:0];

    // Read path: zero latency, always pre-edge state.
    always_comb begin
        bus.readdataM = '0;
        if (is_mmio) begin
            case (off)
                OFF_CYCLE: bus.readdataM = cycle_q;
                OFF_GPIO:  bus.readdataM = 32'(gpio_q);
                OFF_TCMP:  bus.readdataM = tcmp_q;
                OFF_TCTRL: bus.readdataM = {29'b0, pend_q, auto_q, en_q};
                OFF_TCNT:  bus.readdataM = tcnt_q;
                default:   bus.readdataM = '0;
            endcase
        end else begin
            bus.readdataM = mem_q[ram_idx];
        end
    end

    // Next-state logic. The timer update is computed first.
    // CPU writes then override the fields they touch.
    // A hardware PEND set is applied last so that it beats a same-cycle W1C.
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        gpio_d  = gpio_q;
        tcmp_d  = tcmp_q;
        tcnt_d  = tcnt_q;
        en_d    = en_q;
        auto_d  = auto_q;
        pend_d  = pend_q;

        if (match) begin
            if (auto_q) begin
                tcnt_d = '0;
            end else begin
                en_d = 1'b0;
            end
        end else if (en_q) begin
            tcnt_d = tcnt_q + 32'd1;
        end

        if (wr_mmio) begin
            case (off)
                OFF_GPIO:  gpio_d = bus.writedataM[GPIO_W-1:0];
                OFF_TCMP:  tcmp_d = bus.writedataM;
                OFF_TCNT:  tcnt_d = bus.writedataM;
                OFF_TCTRL: begin
                    en_d   = bus.writedataM[0];
                    auto_d = bus.writedataM[1];
                    if (bus.writedataM[2]) begin
                        pend_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (match) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q <= '0;
            gpio_q  <= '0;
            tcmp_q  <= '0;
            tcnt_q  <= '0;
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            gpio_q  <= gpio_d;
            tcmp_q  <= tcmp_d;
            tcnt_q  <= tcnt_d;
            en_q    <= en_d;
            auto_q  <= auto_d;
            pend_q  <= pend_d;
        end
    end

    // The data RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= bus.writedataM;
        end
    end

    assign gpio_out  = gpio_q;
    assign timer_irq = pend_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam logic [31:0] A_CYCLE = 32'hFFFF_FF00;
    localparam logic [31:0] A_GPIO  = 32'hFFFF_FF04;
    localparam logic [31:0] A_TCMP  = 32'hFFFF_FF08;
    localparam logic [31:0] A_TCTRL = 32'hFFFF_FF0C;
    localparam logic [31:0] A_TCNT  = 32'hFFFF_FF10;
    localparam logic [31:0] A_UNMAP = 32'hFFFF_FF20;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] gpio_out;
    logic       timer_irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(
        .RAM_WORDS(64),
        .MMIO_BASE(32'hFFFF_FF00),
        .GPIO_W(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave),
        .gpio_out(gpio_out),
        .timer_irq(timer_irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        bus.memwriteM  = we;
        bus.aluoutM    = addr;
        bus.writedataM = wd;
    endtask

    // Push the expected load value, let the combinational read settle, then pop and compare.
    task automatic expect_rd(input string tag, input logic [31:0] exp);
        string       t;
        logic [31:0] e;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        check(t, bus.readdataM, e);
    endtask

    task automatic tick;
        @(negedge clk);
        bus.memwriteM = 1'b0;
    endtask

    initial begin
        logic [31:0] m_cnt;
        logic        m_pend;
        logic        w1c;
        logic        m_match;

        reset_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_gpio", 32'(gpio_out), 32'h0);
        check("rst_irq", 32'(timer_irq), 32'h0);
        drive(1'b0, A_CYCLE, 32'h0);
        expect_rd("rst_cycle", 32'h0);
        drive(1'b1, A_GPIO, 32'h0000_00FF);
        tick;
        reset_n = 1'b1;
        check("rst_store_dropped", 32'(gpio_out), 32'h0);

        // CYCLE: ten posedges after release
        repeat (10) @(negedge clk);
        drive(1'b1, A_CYCLE, 32'h0);
        expect_rd("cycle_10", 32'd10);
        tick;
        drive(1'b0, A_CYCLE, 32'h0);
        expect_rd("cycle_wr_ignored", 32'd11);

        // RAM write/read, aliasing, read-during-write
        tick;
        drive(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        tick;
        drive(1'b0, 32'h0000_0010, 32'h0);
        expect_rd("ram_rd", 32'hDEAD_BEEF);
        drive(1'b0, 32'h0000_0110, 32'h0);
        expect_rd("ram_alias", 32'hDEAD_BEEF);
        drive(1'b1, 32'h0000_0010, 32'h0000_0001);
        expect_rd("ram_rdw_old", 32'hDEAD_BEEF);
        tick;
        drive(1'b0, 32'h0000_0010, 32'h0);
        expect_rd("ram_rdw_new", 32'h0000_0001);

        // GPIO and unmapped offsets
        tick;
        drive(1'b1, A_GPIO, 32'h1234_56A5);
        check("gpio_before", 32'(gpio_out), 32'h0);
        tick;
        check("gpio_out", 32'(gpio_out), 32'h0000_00A5);
        drive(1'b0, A_GPIO, 32'h0);
        expect_rd("gpio_rd", 32'h0000_00A5);
        drive(1'b1, A_UNMAP, 32'hFFFF_FFFF);
        expect_rd("unmap_rd", 32'h0);
        tick;
        drive(1'b0, A_UNMAP, 32'h0);
        expect_rd("unmap_after_wr", 32'h0);

        // One-shot timer
        tick;
        drive(1'b1, A_TCMP, 32'd3);
        tick;
        drive(1'b1, A_TCNT, 32'd0);
        tick;
        drive(1'b1, A_TCTRL, 32'h1);
        tick;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, A_TCNT, 32'h0);
            expect_rd($sformatf("os_tcnt%0d", i), (i < 3) ? 32'(i) : 32'd3);
            check($sformatf("os_irq%0d", i), 32'(timer_irq), (i >= 4) ? 32'd1 : 32'd0);
            tick;
        end
        drive(1'b0, A_TCTRL, 32'h0);
        expect_rd("os_tctrl", 32'h4);
        drive(1'b1, A_TCTRL, 32'h4);
        tick;
        check("os_w1c_irq", 32'(timer_irq), 32'h0);
        drive(1'b0, A_TCTRL, 32'h0);
        expect_rd("os_w1c_tctrl", 32'h0);

        // Auto-reload timer with W1C on a non-match cycle and on a match cycle
        drive(1'b1, A_TCMP, 32'd2);
        tick;
        drive(1'b1, A_TCNT, 32'd0);
        tick;
        drive(1'b1, A_TCTRL, 32'h3);
        tick;
        m_cnt  = 32'd0;
        m_pend = 1'b0;
        for (int i = 0; i < 10; i++) begin
            w1c = (i == 4) || (i == 8);
            if (w1c) begin
                drive(1'b1, A_TCTRL, 32'h7);
                expect_rd($sformatf("ar_tctrl%0d", i), {29'b0, m_pend, 2'b11});
            end else begin
                drive(1'b0, A_TCNT, 32'h0);
                expect_rd($sformatf("ar_tcnt%0d", i), m_cnt);
            end
            check($sformatf("ar_irq%0d", i), 32'(timer_irq), 32'(m_pend));
            m_match = (m_cnt == 32'd2);
            if (m_match) begin
                m_pend = 1'b1;
                m_cnt  = 32'd0;
            end else begin
                if (w1c) m_pend = 1'b0;
                m_cnt = m_cnt + 32'd1;
            end
            tick;
        end

        // Asynchronous reset between clock edges
        check("ar_pre_reset_irq", 32'(timer_irq), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_irq", 32'(timer_irq), 32'h0);
        check("async_gpio", 32'(gpio_out), 32'h0);
        drive(1'b0, A_TCNT, 32'h0);
        expect_rd("async_tcnt", 32'h0);
        drive(1'b0, A_CYCLE, 32'h0);
        expect_rd("async_cycle", 32'h0);
        drive(1'b0, 32'h0000_0010, 32'h0);
        expect_rd("async_ram_kept", 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
